// File: rtl/truth_table_sequencer_if.sv
// +--------------------------------------------------------------------------+
// | truth_table_sequencer_if                                                  |
// | Stimulus, response and result signals of the truth-table sequencer.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface truth_table_sequencer_if;
  logic        start;
  logic [15:0] exp_x;
  logic [15:0] exp_y;
  logic        x_in;
  logic        y_in;
  logic [3:0]  abcd_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [4:0]  err_count;
  logic        fail_valid;
  logic [3:0]  first_fail_idx;

  // Sequencer side.
  modport master (
    input  start, exp_x, exp_y, x_in, y_in,
    output abcd_out, busy, done, pass, err_count, fail_valid, first_fail_idx
  );

  // Controlling environment and block-under-test side.
  modport slave (
    output start, exp_x, exp_y, x_in, y_in,
    input  abcd_out, busy, done, pass, err_count, fail_valid, first_fail_idx
  );
endinterface

`default_nettype wire

// File: rtl/truth_table_sequencer.sv
// +--------------------------------------------------------------------------+
// | truth_table_sequencer                                                     |
// | Walks a 4-input block through all 16 vectors and checks X/Y responses.    |
// | Optional macro SEQ_STOP_ON_FAIL_EN: end the run at the first mismatch.    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module truth_table_sequencer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  truth_table_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] c_last_idx    = 4'd15;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_idx, w_idx_nxt;
  logic [3:0] r_settle_cnt, w_settle_cnt_nxt;
  logic [4:0] r_err_count, w_err_count_nxt;
  logic       r_fail_valid, w_fail_valid_nxt;
  logic [3:0] r_first_fail_idx, w_first_fail_idx_nxt;
  logic       w_mismatch;
  logic       w_stop;

  assign w_mismatch = (bus.x_in != bus.exp_x[r_idx]) || (bus.y_in != bus.exp_y[r_idx]);

`ifdef SEQ_STOP_ON_FAIL_EN
  assign w_stop = w_mismatch;
`else
  assign w_stop = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_idx            <= 4'd0;
      r_settle_cnt     <= 4'd0;
      r_err_count      <= 5'd0;
      r_fail_valid     <= 1'b0;
      r_first_fail_idx <= 4'd0;
    end else begin
      r_state          <= w_state_nxt;
      r_idx            <= w_idx_nxt;
      r_settle_cnt     <= w_settle_cnt_nxt;
      r_err_count      <= w_err_count_nxt;
      r_fail_valid     <= w_fail_valid_nxt;
      r_first_fail_idx <= w_first_fail_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt          = r_state;
    w_idx_nxt            = r_idx;
    w_settle_cnt_nxt     = r_settle_cnt;
    w_err_count_nxt      = r_err_count;
    w_fail_valid_nxt     = r_fail_valid;
    w_first_fail_idx_nxt = r_first_fail_idx;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        // first_fail_idx is left alone; it is only meaningful with fail_valid.
        if (bus.start) begin
          w_state_nxt      = ST_APPLY;
          w_idx_nxt        = 4'd0;
          w_err_count_nxt  = 5'd0;
          w_fail_valid_nxt = 1'b0;
        end
      end
      ST_APPLY: begin
        w_state_nxt      = ST_SETTLE;
        w_settle_cnt_nxt = 4'd0;
      end
      ST_SETTLE: begin
        if (r_settle_cnt == c_settle_last) begin
          w_state_nxt = ST_SAMPLE;
        end else begin
          w_settle_cnt_nxt = r_settle_cnt + 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (w_mismatch) begin
          w_err_count_nxt = r_err_count + 5'd1;
          if (!r_fail_valid) begin
            w_fail_valid_nxt     = 1'b1;
            w_first_fail_idx_nxt = r_idx;
          end
        end
        if (w_stop || (r_idx == c_last_idx)) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_APPLY;
          w_idx_nxt   = r_idx + 4'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.abcd_out       = r_idx;
  assign bus.busy           = (r_state == ST_APPLY) || (r_state == ST_SETTLE) ||
                              (r_state == ST_SAMPLE);
  assign bus.done           = (r_state == ST_DONE);
  assign bus.pass           = (r_state == ST_DONE) && (r_err_count == 5'd0);
  assign bus.err_count      = r_err_count;
  assign bus.fail_valid     = r_fail_valid;
  assign bus.first_fail_idx = r_first_fail_idx;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: a modelled 4-input block with per-vector fault
// injection, a table of full runs, and hand-written reset / DONE-hold sequences.
`default_nettype none

module tb_truth_table_sequencer;

  localparam int SETTLE = 4;
  localparam int PER_VEC = SETTLE + 2;

  logic clk;
  logic reset;
  truth_table_sequencer_if bus ();

  truth_table_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference block: X = A^B^C^D, Y = (A&B)|(C&D), with optional per-vector inversion.
  logic [15:0] inj_x, inj_y;

  function automatic logic fx(input logic [3:0] v);
    return ^v;
  endfunction

  function automatic logic fy(input logic [3:0] v);
    return (v[3] & v[2]) | (v[1] & v[0]);
  endfunction

  assign bus.x_in = fx(bus.abcd_out) ^ inj_x[bus.abcd_out];
  assign bus.y_in = fy(bus.abcd_out) ^ inj_y[bus.abcd_out];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] ix;
    logic [15:0] iy;
    int          poke;      // busy cycle at which to pulse start, -1 for none
    int          busy_cyc;
    int          err;
    bit          fv;
    int          first;
    bit          pass;
    int          abcd;
  } vec_t;

  task automatic run_row(input vec_t v);
    int cnt;
    int seq_bad;
    inj_x = v.ix;
    inj_y = v.iy;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    seq_bad = 0;
    while (bus.busy && cnt < 400) begin
      if (int'(bus.abcd_out) != cnt / PER_VEC) seq_bad++;
      if (cnt == v.poke) bus.start = 1'b1;
      else bus.start = 1'b0;
      cnt++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk({v.name, ":busy_cycles"}, cnt, v.busy_cyc);
    chk({v.name, ":abcd_seq_errs"}, seq_bad, 0);
    chk({v.name, ":done"}, int'(bus.done), 1);
    chk({v.name, ":pass"}, int'(bus.pass), int'(v.pass));
    chk({v.name, ":err_count"}, int'(bus.err_count), v.err);
    chk({v.name, ":fail_valid"}, int'(bus.fail_valid), int'(v.fv));
    if (v.fv) chk({v.name, ":first_fail_idx"}, int'(bus.first_fail_idx), v.first);
    chk({v.name, ":abcd_out"}, int'(bus.abcd_out), v.abcd);
  endtask

  vec_t tbl[6];

  initial begin
    int k;
    logic [15:0] ex, ey;
    logic [15:0] mid_iy;

    for (int i = 0; i < 16; i++) begin
      ex[i] = fx(4'(i));
      ey[i] = fy(4'(i));
    end

`ifdef SEQ_STOP_ON_FAIL_EN
    tbl[0] = '{"full_pass",   16'h0000, 16'h0000, -1, 96, 0,  1'b0, 0, 1'b1, 15};
    tbl[1] = '{"y_fault_5_9", 16'h0000, 16'h0220, -1, 36, 1,  1'b1, 5, 1'b0, 5};
    tbl[2] = '{"start_busy",  16'h0000, 16'h0000, 42, 96, 0,  1'b0, 0, 1'b1, 15};
    tbl[3] = '{"x_fault_3",   16'h0008, 16'h0000, -1, 24, 1,  1'b1, 3, 1'b0, 3};
    tbl[4] = '{"xy_fault_0",  16'h8001, 16'h0001, -1, 6,  1,  1'b1, 0, 1'b0, 0};
    tbl[5] = '{"y_all_bad",   16'h0000, 16'hFFFF, -1, 6,  1,  1'b1, 0, 1'b0, 0};
    mid_iy = 16'h0000;
`else
    tbl[0] = '{"full_pass",   16'h0000, 16'h0000, -1, 96, 0,  1'b0, 0, 1'b1, 15};
    tbl[1] = '{"y_fault_5_9", 16'h0000, 16'h0220, -1, 96, 2,  1'b1, 5, 1'b0, 15};
    tbl[2] = '{"start_busy",  16'h0000, 16'h0000, 42, 96, 0,  1'b0, 0, 1'b1, 15};
    tbl[3] = '{"x_fault_3",   16'h0008, 16'h0000, -1, 96, 1,  1'b1, 3, 1'b0, 15};
    tbl[4] = '{"xy_fault_0",  16'h8001, 16'h0001, -1, 96, 2,  1'b1, 0, 1'b0, 15};
    tbl[5] = '{"y_all_bad",   16'h0000, 16'hFFFF, -1, 96, 16, 1'b1, 0, 1'b0, 15};
    mid_iy = 16'h0004;
`endif

    // Reset, then idle with no start.
    inj_x = 16'h0000;
    inj_y = 16'h0000;
    bus.start = 1'b0;
    bus.exp_x = ex;
    bus.exp_y = ey;
    reset = 1'b1;
    #2;
    chk("rst:abcd_out", int'(bus.abcd_out), 0);
    chk("rst:busy", int'(bus.busy), 0);
    chk("rst:err_count", int'(bus.err_count), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("idle:abcd_out", int'(bus.abcd_out), 0);
    chk("idle:busy", int'(bus.busy), 0);
    chk("idle:done", int'(bus.done), 0);
    chk("idle:pass", int'(bus.pass), 0);

    for (int r = 0; r < 6; r++) run_row(tbl[r]);

    // DONE holds results while the expectation words change outside SAMPLE.
    run_row(tbl[1]);
    bus.exp_x = ~ex;
    bus.exp_y = ~ey;
    repeat (8) @(negedge clk);
    chk("hold:done", int'(bus.done), 1);
    chk("hold:err_count", int'(bus.err_count), tbl[1].err);
    chk("hold:first_fail_idx", int'(bus.first_fail_idx), 5);
    chk("hold:abcd_out", int'(bus.abcd_out), tbl[1].abcd);
    bus.exp_x = ex;
    bus.exp_y = ey;

    // Reset in the middle of vector 10 clears everything without a clock edge.
    inj_x = 16'h0000;
    inj_y = mid_iy;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    while (bus.abcd_out != 4'd10 && k < 200) begin
      k++;
      @(negedge clk);
    end
    chk("mid:reached_v10", int'(bus.abcd_out), 10);
    #2;
    reset = 1'b1;
    #1;
    chk("mid:abcd_out", int'(bus.abcd_out), 0);
    chk("mid:busy", int'(bus.busy), 0);
    chk("mid:done", int'(bus.done), 0);
    chk("mid:pass", int'(bus.pass), 0);
    chk("mid:err_count", int'(bus.err_count), 0);
    chk("mid:fail_valid", int'(bus.fail_valid), 0);
    chk("mid:first_fail_idx", int'(bus.first_fail_idx), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid:idle_after", int'(bus.busy), 0);
    run_row(tbl[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
